// File: rtl/sim_harness_ctrl_if.sv
// sim_harness_ctrl_if: data-memory store snoop bus plus retire strobe.
// Ports: wr_valid[N_WR], wr_addr/wr_data packed per port at [i*W +: W], retire.
interface sim_harness_ctrl_if #(
  parameter int N_WR   = 1,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();
  logic [N_WR-1:0]        wr_valid;
  logic [N_WR*ADDR_W-1:0] wr_addr;
  logic [N_WR*DATA_W-1:0] wr_data;
  logic                   retire;
  modport master (output wr_valid, wr_addr, wr_data, retire);
  modport slave  (input  wr_valid, wr_addr, wr_data, retire);
endinterface

// File: rtl/sim_harness_ctrl.sv
// sim_harness_ctrl: core reset sequencer, tohost pass/fail detector and cycle watchdog.
// Ports: clk, reset_n (sync, active-low), bus (snooped stores + retire),
//   core_reset_n, sticky done/pass/fail/timeout, fail_code, cycle_count, retire_count.
module sim_harness_ctrl #(
  parameter int                N_WR           = 1,
  parameter int                ADDR_W         = 32,
  parameter int                DATA_W         = 32,
  parameter int                CNT_W          = 32,
  parameter int                RESET_CYCLES   = 4,
  parameter int                TIMEOUT_CYCLES = 5000,
  parameter logic [ADDR_W-1:0] TOHOST_ADDR    = 'h1000,
  parameter bit                HALT_ON_DONE   = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  sim_harness_ctrl_if.slave    bus,
  output logic                 core_reset_n,
  output logic                 done,
  output logic                 pass,
  output logic                 fail,
  output logic                 timeout,
  output logic [DATA_W-2:0]    fail_code,
  output logic [CNT_W-1:0]     cycle_count,
  output logic [CNT_W-1:0]     retire_count
);
  localparam int HW = RESET_CYCLES > 1 ? $clog2(RESET_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  typedef enum logic [2:0] {HOLD, RUN, PASS, FAIL, TMO} state_t;
  state_t state, state_n;
  logic [HW-1:0] hold_cnt;
  logic hit, expire, term;
  logic [DATA_W-1:0] hit_data;
  // scan from the top so the lowest-index hit is the one left standing
  always_comb begin
    hit = 1'b0;
    hit_data = '0;
    for (int i = N_WR - 1; i >= 0; i--)
      if (bus.wr_valid[i] && bus.wr_addr[i*ADDR_W +: ADDR_W] == TOHOST_ADDR && bus.wr_data[i*DATA_W]) begin
        hit = 1'b1;
        hit_data = bus.wr_data[i*DATA_W +: DATA_W];
      end
  end
  assign expire = (TIMEOUT_CYCLES != 0) && (cycle_count == TO_LAST);
  always_comb begin
    state_n = state;
    if (state == HOLD && hold_cnt == HOLD_LAST) state_n = RUN;
    if (state == RUN) state_n = hit ? (hit_data == DATA_W'(1) ? PASS : FAIL) : expire ? TMO : RUN;
  end
  assign term = state_n == PASS || state_n == FAIL || state_n == TMO;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= HOLD;
      hold_cnt <= '0;
      core_reset_n <= 1'b0;
      done <= 1'b0;
      pass <= 1'b0;
      fail <= 1'b0;
      timeout <= 1'b0;
      fail_code <= '0;
      cycle_count <= '0;
      retire_count <= '0;
    end else begin
      state <= state_n;
      hold_cnt <= state == HOLD ? hold_cnt + HW'(1) : hold_cnt;
      core_reset_n <= state_n == RUN || (!HALT_ON_DONE && term);
      done <= term;
      pass <= state_n == PASS;
      fail <= state_n == FAIL;
      timeout <= state_n == TMO;
      if (state == RUN) begin
        cycle_count <= cycle_count + CNT_W'(~&cycle_count);
        retire_count <= retire_count + CNT_W'(bus.retire && ~&retire_count);
        if (state_n == FAIL) fail_code <= hit_data[DATA_W-1:1];
      end
    end
  end
endmodule

// File: tb/tb_sim_harness_ctrl.sv
// tb_sim_harness_ctrl: directed, table-driven and random checks of two controller configurations.
module tb_sim_harness_ctrl;
  localparam int RC = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int CW = 32;
  localparam longint MAXC = (longint'(1) << CW) - 1;
  localparam int TO[2] = '{150, 50};
  localparam bit HALT[2] = '{1'b1, 1'b0};
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;
  sim_harness_ctrl_if #(.N_WR(2), .ADDR_W(AW), .DATA_W(DW)) bus ();
  logic [1:0] crn, dn, ps, fl, tm;
  logic [DW-2:0] fc [2];
  logic [CW-1:0] cc [2];
  logic [CW-1:0] rcn [2];
  sim_harness_ctrl #(.N_WR(2), .RESET_CYCLES(RC), .TIMEOUT_CYCLES(150), .HALT_ON_DONE(1'b1)) dut0 (
    .clk(clk), .reset_n(reset_n), .bus(bus.slave), .core_reset_n(crn[0]), .done(dn[0]), .pass(ps[0]),
    .fail(fl[0]), .timeout(tm[0]), .fail_code(fc[0]), .cycle_count(cc[0]), .retire_count(rcn[0]));
  sim_harness_ctrl #(.N_WR(2), .RESET_CYCLES(RC), .TIMEOUT_CYCLES(50), .HALT_ON_DONE(1'b0)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(bus.slave), .core_reset_n(crn[1]), .done(dn[1]), .pass(ps[1]),
    .fail(fl[1]), .timeout(tm[1]), .fail_code(fc[1]), .cycle_count(cc[1]), .retire_count(rcn[1]));
  int n_chk = 0;
  int n_err = 0;
  int m_edges [2];
  bit m_done [2], m_pass [2], m_fail [2], m_tmo [2];
  logic [DW-2:0] m_code [2];
  longint m_cyc [2], m_ret [2];
  typedef struct {
    logic [1:0] v;
    logic [31:0] a0, d0, a1, d1;
    logic ep, ef;
    logic [30:0] ec;
  } vec_t;
  vec_t vt [10];
  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // reference: edges since release, first matching port, arithmetic counters
  task automatic model_step(int d);
    int h;
    bit exp_now;
    logic [DW-1:0] hd;
    h = -1;
    if (!reset_n) begin
      m_edges[d] = 0; m_done[d] = 0; m_pass[d] = 0; m_fail[d] = 0; m_tmo[d] = 0;
      m_code[d] = '0; m_cyc[d] = 0; m_ret[d] = 0;
    end else if (!m_done[d]) begin
      if (m_edges[d] < RC) m_edges[d]++;
      else begin
        for (int i = 0; i < 2; i++)
          if (h < 0 && bus.wr_valid[i] && bus.wr_addr[i*AW +: AW] == 32'h1000 && bus.wr_data[i*DW]) h = i;
        exp_now = TO[d] != 0 && m_cyc[d] == longint'(TO[d] - 1);
        if (m_cyc[d] < MAXC) m_cyc[d]++;
        if (bus.retire && m_ret[d] < MAXC) m_ret[d]++;
        if (h >= 0) begin
          hd = bus.wr_data[h*DW +: DW];
          m_done[d] = 1;
          if (hd == 1) m_pass[d] = 1;
          else begin
            m_fail[d] = 1;
            m_code[d] = hd[DW-1:1];
          end
        end else if (exp_now) begin
          m_done[d] = 1;
          m_tmo[d] = 1;
        end
      end
    end
  endtask
  task automatic compare_all();
    bit core_exp;
    for (int d = 0; d < 2; d++) begin
      core_exp = m_edges[d] >= RC && (!m_done[d] || !HALT[d]);
      check($sformatf("dut%0d_outputs", d),
            {crn[d], dn[d], ps[d], fl[d], tm[d], fc[d], cc[d], rcn[d]},
            {core_exp, m_done[d], m_pass[d], m_fail[d], m_tmo[d], m_code[d], CW'(m_cyc[d]), CW'(m_ret[d])});
    end
  endtask
  task automatic step();
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
    compare_all();
  endtask
  task automatic clr();
    bus.wr_valid = '0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.retire = 1'b0;
  endtask
  task automatic wr(int p, logic [31:0] a, logic [31:0] d);
    bus.wr_valid[p] = 1'b1;
    bus.wr_addr[p*AW +: AW] = a;
    bus.wr_data[p*DW +: DW] = d;
  endtask
  task automatic do_reset(int n);
    clr();
    reset_n = 1'b0;
    repeat (n) step();
    reset_n = 1'b1;
  endtask
  task automatic start();
    do_reset(2);
    repeat (RC) step();
  endtask
  initial begin
    vt[0] = '{2'b01, 32'h1000, 32'h1, 32'h0, 32'h0, 1'b1, 1'b0, 31'h0};
    vt[1] = '{2'b01, 32'h1000, 32'h7, 32'h0, 32'h0, 1'b0, 1'b1, 31'h3};
    vt[2] = '{2'b01, 32'h1000, 32'h2, 32'h0, 32'h0, 1'b0, 1'b0, 31'h0};
    vt[3] = '{2'b11, 32'h1000, 32'h5, 32'h1000, 32'h1, 1'b0, 1'b1, 31'h2};
    vt[4] = '{2'b11, 32'h1000, 32'h4, 32'h1000, 32'h1, 1'b1, 1'b0, 31'h0};
    vt[5] = '{2'b01, 32'h1004, 32'h1, 32'h0, 32'h0, 1'b0, 1'b0, 31'h0};
    vt[6] = '{2'b00, 32'h1000, 32'h1, 32'h0, 32'h0, 1'b0, 1'b0, 31'h0};
    vt[7] = '{2'b10, 32'h0, 32'h0, 32'h1000, 32'h9, 1'b0, 1'b1, 31'h4};
    vt[8] = '{2'b01, 32'h1000, 32'hffff_ffff, 32'h0, 32'h0, 1'b0, 1'b1, 31'h7fff_ffff};
    vt[9] = '{2'b11, 32'h2000, 32'h1, 32'h1000, 32'h3, 1'b0, 1'b1, 31'h1};
    clr();
    reset_n = 1'b0;
    repeat (3) step();
    reset_n = 1'b1;
    for (int k = 1; k <= RC; k++) begin
      step();
      check($sformatf("t1_core_reset_edge%0d", k), crn[0], k == RC);
      check($sformatf("t1_status_edge%0d", k), {dn, ps, fl, tm}, 0);
    end
    for (int i = 0; i < 100; i++) begin
      bus.retire = i < 60;
      step();
    end
    clr();
    wr(0, 32'h1000, 32'h1);
    step();
    clr();
    check("t2_pass", {dn[0], ps[0], fl[0], tm[0]}, 4'b1100);
    check("t2_cycle_count", cc[0], 101);
    check("t2_retire_count", rcn[0], 60);
    check("t2_core_halted", crn[0], 0);
    check("t4_timeout", {dn[1], ps[1], fl[1], tm[1]}, 4'b1001);
    check("t4_cycle_count", cc[1], 50);
    check("t4_core_not_halted", crn[1], 1);
    bus.retire = 1'b1;
    wr(1, 32'h1000, 32'h3);
    repeat (10) step();
    clr();
    check("t2_frozen_cycles", cc[0], 101);
    check("t2_frozen_retires", rcn[0], 60);
    check("t2_still_pass", {ps[0], fl[0]}, 2'b10);
    start();
    repeat (49) step();
    wr(0, 32'h1000, 32'h1);
    step();
    clr();
    check("t4b_pass_beats_expiry", {dn[1], ps[1], tm[1]}, 3'b110);
    check("t4b_cycle_count", cc[1], 50);
    for (int v = 0; v < 10; v++) begin
      start();
      repeat (5) step();
      bus.wr_valid = vt[v].v;
      bus.wr_addr = {vt[v].a1, vt[v].a0};
      bus.wr_data = {vt[v].d1, vt[v].d0};
      step();
      clr();
      check($sformatf("vec%0d_flags", v), {dn[0], ps[0], fl[0]}, {vt[v].ep | vt[v].ef, vt[v].ep, vt[v].ef});
      check($sformatf("vec%0d_fail_code", v), fc[0], vt[v].ec);
      if (vt[v].ep || vt[v].ef) begin
        wr(0, 32'h1000, vt[v].ep ? 32'h3 : 32'h1);
        wr(1, 32'h1000, 32'h2);
        step();
        clr();
        check($sformatf("vec%0d_sticky", v), {ps[0], fl[0], fc[0]}, {vt[v].ep, vt[v].ef, vt[v].ec});
      end
    end
    start();
    repeat (30) step();
    reset_n = 1'b0;
    step();
    check("t6_all_zero", {crn[0], dn[0], ps[0], fl[0], tm[0], fc[0], cc[0], rcn[0]}, 0);
    reset_n = 1'b1;
    for (int k = 1; k <= RC; k++) begin
      step();
      check($sformatf("t6_core_reset_edge%0d", k), crn[0], k == RC);
    end
    for (int r = 0; r < 25; r++) begin
      do_reset($urandom_range(1, 3));
      for (int c = $urandom_range(20, 220); c > 0; c--) begin
        clr();
        bus.retire = 1'($urandom);
        for (int p = 0; p < 2; p++)
          if ($urandom_range(0, 1) == 1)
            wr(p, $urandom_range(0, 7) == 0 ? 32'h1000 : $urandom, $urandom_range(0, 3) == 0 ? 32'h1 : $urandom);
        reset_n = $urandom_range(0, 99) != 0;
        step();
      end
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
